port_io: RTL
============

Name: port_io

Overview:
- Peripheral block on the CPU port bus (portaddr/portval/portget/portset/portout).
- Owns two display registers, an LED register, synchronized switch input, debounced buttons with sticky press latches, and a 16-bit timer with compare flag.
- Downstream of cpu; upstream of ssd_driver, which it feeds through show_val.

Parameters:
WORD_SIZE, 16, width of port address/data words
DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles before a button level change is accepted (min 2)
NUM_BTN, 4, number of buttons

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
portaddr  input  WORD_SIZE  port address; only bits [2:0] decoded, upper bits ignored
portval  input  WORD_SIZE  write data
portget  input  1  read strobe, one cycle
portset  input  1  write strobe, one cycle
portout  output  WORD_SIZE  registered read data
sw  input  8  raw switches
btn  input  NUM_BTN  raw buttons
show_val  output  16  value to ssd_driver
led  output  8  LED register

Behaviour:
- Reset (async, rst=1): disp0, disp1, led_reg, timer, compare, press latches, debounced levels, debounce counters, sync flops, timer flag and portout all 0.
- Inputs sw and btn pass through a 2-FF synchronizer. Reads and show_val use synchronized values, so an sw change is visible 2 cycles later.
- Address map (addr = portaddr[2:0]):
  - 0 = disp0 (R/W).
  - 1 = disp1 (R/W).
  - 2 = led_reg (R/W, low 8 bits; reads zero-extended).
  - 3 = switches (RO; writes ignored).
  - 4 = buttons (RO): read = {latch[3:0] in bits 7:4, level[3:0] in bits 3:0}, zero-extended.
  - 5 = timer count (R/W; write loads count).
  - 6 = compare (R/W).
  - 7 = status (bit0 = timer flag; write with portval[0]=1 clears the flag, write with portval[0]=0 has no effect).
- show_val = sync_sw[0] ? disp1 : disp0, combinational from registers.
- led = led_reg.
- Writes: on posedge clk with portset=1, the addressed register takes portval. This is visible on read and on show_val the following cycle.
- Reads:
  - On posedge clk with portget=1, portout <= addressed value. Read latency is 1 cycle.
  - portout holds its value until the next read.
  - If portget and portset are both asserted, the write takes effect and the read returns the pre-write value.
- Debounce, per button:
  - A counter increments while sync_btn != level and resets to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with inputs still differing, level <= sync_btn and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes level.
- Press latch: set on a level 0->1 transition.
  - A read of addr 4 clears exactly the latch bits that read returned as 1.
  - A new press in the same cycle as the clearing read leaves the bit set. Set wins.
- Timer:
  - Increments every cycle and wraps 0xFFFF -> 0.
  - When count == compare (checked every cycle), the flag is set and count <= 0 next cycle instead of incrementing.
  - A write to addr 5 overrides the increment and reload that cycle.
  - If a flag-set and a flag-clear write happen in the same cycle, set wins.
  - compare = 0 makes the flag set every cycle and holds count at 0.
- Mid-operation reset: all state, including partially debounced counts, clears immediately; no latch survives.

Test Plan:
- Reset then write 0x1234 to addr 0 and 0xABCD to addr 1 with sw=0: show_val=0x1234. Set sw[0]=1: show_val=0xABCD exactly 2 cycles later. Read addr 1: portout=0xABCD 1 cycle after portget.
- Write 0x00A5 to addr 2: led=0xA5. Read addr 3 with sw=0x3C: portout=0x003C. Write to addr 3: no change to any register.
- Pulse btn[2] high for DEBOUNCE_CYCLES-2 cycles: level and latch stay 0. Hold it for 40 cycles: read addr 4 = 0x0044. Read again while still held: 0x0004.
- Press btn[0] so its latch sets in the same cycle as a clearing read of addr 4: latch bit 0 remains 1 on the next read.
- Write compare=9, write count=0: the flag sets 9 cycles after the load and count returns to 0. Read addr 7 = 0x0001. Write 1 to addr 7: the next read = 0 unless a match occurs in the same cycle.
- Assert rst asynchronously mid-debounce and with the flag set: all outputs are 0 before the next clk edge, and a subsequent read of addr 4 = 0x0000.

Source files
------------

// File: rtl/port_io.sv
// port_io: CPU port-bus peripheral with display/LED registers, synchronized
// switches, debounced buttons with sticky press latches and a compare timer.

// One button lane: debounce of an already-synchronized level plus press latch.
module port_io_btn #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in,     // synchronized raw button
  input  logic clr,    // clear latch (bit was returned as 1 by a read)
  output logic level,  // debounced level
  output logic latch   // sticky press latch
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;
  logic          accept;
  logic          rise;

  // Input has differed long enough: take it on this edge.
  assign accept = (in != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise   = accept && in;

  // Debounce counter, accepted level and press latch (a new press beats a clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      latch <= 1'b0;
    end else begin
      if (in == level)  cnt <= '0;
      else if (accept) begin
        cnt   <= '0;
        level <= in;
      end else          cnt <= cnt + 1'b1;
      latch <= (latch & ~clr) | rise;
    end
  end
endmodule

module port_io #(
  parameter int WORD_SIZE       = 16,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_BTN         = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] portaddr,
  input  logic [WORD_SIZE-1:0] portval,
  input  logic                 portget,
  input  logic                 portset,
  output logic [WORD_SIZE-1:0] portout,
  input  logic [7:0]           sw,
  input  logic [NUM_BTN-1:0]   btn,
  output logic [15:0]          show_val,
  output logic [7:0]           led
);
  localparam logic [2:0] A_DISP0 = 3'd0, A_DISP1 = 3'd1, A_LED = 3'd2,
                         A_SW    = 3'd3, A_BTN   = 3'd4, A_CNT = 3'd5,
                         A_CMP   = 3'd6, A_STAT  = 3'd7;

  logic [2:0]           addr;
  logic [15:0]          disp0, disp1, tmr_cnt, tmr_cmp;
  logic [7:0]           led_reg, sw_s1, sw_s2;
  logic [NUM_BTN-1:0]   btn_s1, btn_s2, btn_lvl, btn_lat, btn_clr;
  logic                 tmr_flag, match, wr_cnt, clr_flag;
  logic [WORD_SIZE-1:0] rdata;
  logic                 unused_bits;

  assign addr        = portaddr[2:0];
  assign unused_bits = ^{portaddr, portval};
  assign show_val    = sw_s2[0] ? disp1 : disp0;
  assign led         = led_reg;
  assign match       = (tmr_cnt == tmr_cmp);
  assign wr_cnt      = portset && (addr == A_CNT);
  assign clr_flag    = portset && (addr == A_STAT) && portval[0];
  // A read of the button port clears exactly the latch bits it returned.
  assign btn_clr     = (portget && addr == A_BTN) ? btn_lat : '0;

  // Two-flop synchronizers for the asynchronous switch and button inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_BTN; i++) begin : g_btn
      port_io_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk   (clk),
        .rst   (rst),
        .in    (btn_s2[i]),
        .clr   (btn_clr[i]),
        .level (btn_lvl[i]),
        .latch (btn_lat[i])
      );
    end
  endgenerate

  // Read mux over the current (pre-write) register values.
  always_comb begin
    rdata = '0;
    case (addr)
      A_DISP0: rdata = WORD_SIZE'(disp0);
      A_DISP1: rdata = WORD_SIZE'(disp1);
      A_LED:   rdata = WORD_SIZE'(led_reg);
      A_SW:    rdata = WORD_SIZE'(sw_s2);
      A_BTN:   rdata = WORD_SIZE'({4'(btn_lat), 4'(btn_lvl)});
      A_CNT:   rdata = WORD_SIZE'(tmr_cnt);
      A_CMP:   rdata = WORD_SIZE'(tmr_cmp);
      A_STAT:  rdata = WORD_SIZE'(tmr_flag);
      default: rdata = '0;
    endcase
  end

  // Bus-writable registers and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp0   <= '0;
      disp1   <= '0;
      led_reg <= '0;
      tmr_cmp <= '0;
      portout <= '0;
    end else begin
      if (portset) begin
        case (addr)
          A_DISP0: disp0   <= portval[15:0];
          A_DISP1: disp1   <= portval[15:0];
          A_LED:   led_reg <= portval[7:0];
          A_CMP:   tmr_cmp <= portval[15:0];
          default: ;
        endcase
      end
      if (portget) portout <= rdata;
    end
  end

  // Timer: a bus load beats compare reload, which beats increment; flag set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_cnt  <= '0;
      tmr_flag <= 1'b0;
    end else begin
      if (wr_cnt)     tmr_cnt <= portval[15:0];
      else if (match) tmr_cnt <= '0;
      else            tmr_cnt <= tmr_cnt + 16'd1;
      tmr_flag <= match | (tmr_flag & ~clr_flag);
    end
  end
endmodule
